// File: rtl/ser_shared2.sv
// ser_shared2: splits a parallel word into SER_WIDTH-wide flits, lowest chunk
// first. Each word uses one of two flit counts (COUNT_0 or COUNT_1), chosen by
// count_sel on the word's first flit. The datapath is combinational. A one-hot
// chunk counter and a select latch hold the per-word progress.
module ser_shared2 #(
  parameter int SER_WIDTH = 16,
  parameter int COUNT_0   = 2,
  parameter int COUNT_1   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         count_sel,
  input  logic [SER_WIDTH*COUNT_0-1:0] parallel_in_0,
  input  logic [SER_WIDTH*COUNT_1-1:0] parallel_in_1,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic [SER_WIDTH-1:0]         serial_out,
  output logic                         valid_out,
  output logic                         last_out,
  input  logic                         ready_in
);

  localparam int COUNT_MAX = (COUNT_0 > COUNT_1) ? COUNT_0 : COUNT_1;

  logic [COUNT_MAX-1:0] cnt_q, cnt_d;
  logic                 sel_q, sel_d;
  logic                 eff_sel;
  logic                 last;
  logic                 xfer;
  logic [SER_WIDTH-1:0] chunk_0 [COUNT_0];
  logic [SER_WIDTH-1:0] chunk_1 [COUNT_1];

  // Break both parallel words into their chunk slices.
  for (genvar gi = 0; gi < COUNT_0; gi++) begin : g_chunk0
    assign chunk_0[gi] = parallel_in_0[gi*SER_WIDTH +: SER_WIDTH];
  end
  for (genvar gi = 0; gi < COUNT_1; gi++) begin : g_chunk1
    assign chunk_1[gi] = parallel_in_1[gi*SER_WIDTH +: SER_WIDTH];
  end

  // The select comes live from count_sel on the first flit and from the latch afterwards.
  assign eff_sel   = cnt_q[0] ? count_sel : sel_q;
  assign last      = eff_sel ? cnt_q[COUNT_1-1] : cnt_q[COUNT_0-1];
  assign xfer      = valid_in & ready_in;
  assign valid_out = valid_in;
  assign last_out  = last;
  assign ready_out = xfer & last;

  // Output mux: OR together the chunks whose one-hot counter bit is set.
  always_comb begin
    serial_out = '0;
    if (eff_sel) begin
      for (int i = 0; i < COUNT_1; i++) begin
        if (cnt_q[i]) serial_out = serial_out | chunk_1[i];
      end
    end else begin
      for (int i = 0; i < COUNT_0; i++) begin
        if (cnt_q[i]) serial_out = serial_out | chunk_0[i];
      end
    end
  end

  // Next state: advance or restart the counter on a transfer, and latch the select on the first flit.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (xfer) begin
      if (cnt_q[0]) sel_d = count_sel;
      if (last) begin
        cnt_d = COUNT_MAX'(1);
      end else begin
        cnt_d = (cnt_q << 1) | (cnt_q >> (COUNT_MAX - 1));
      end
    end
  end

  // State register. The active-low synchronous reset overrides any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= COUNT_MAX'(1);
      sel_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: tb/tb_ser_shared2.sv
// Testbench for ser_shared2 with the default parameters (16-bit flits, COUNT_0=2, COUNT_1=1).
// Directed steps are followed by a randomized phase. Each cycle is checked
// against a word/flit-index reference model.
module tb_ser_shared2;

  logic        clk = 1'b0;
  logic        rst;
  logic        count_sel;
  logic [31:0] parallel_in_0;
  logic [15:0] parallel_in_1;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] serial_out;
  logic        valid_out;
  logic        last_out;
  logic        ready_in;

  int checks = 0;
  int errors = 0;

  // Reference model state: index of the next flit within the current word,
  // plus the select that the word in flight started with.
  int   m_idx = 0;
  logic m_sel = 1'b0;

  ser_shared2 #(.SER_WIDTH(16), .COUNT_0(2), .COUNT_1(1)) dut (
    .clk(clk), .rst(rst), .count_sel(count_sel),
    .parallel_in_0(parallel_in_0), .parallel_in_1(parallel_in_1),
    .valid_in(valid_in), .ready_out(ready_out), .serial_out(serial_out),
    .valid_out(valid_out), .last_out(last_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Work out the expected outputs from the model and compare them with the DUT.
  task automatic model_check();
    logic        esel;
    int          n;
    logic [63:0] word;
    logic [15:0] eflit;
    logic        elast;
    esel  = (m_idx == 0) ? count_sel : m_sel;
    n     = esel ? 1 : 2;
    word  = esel ? {48'h0, parallel_in_1} : {32'h0, parallel_in_0};
    eflit = 16'(word >> (m_idx * 16));
    elast = (m_idx == n - 1);
    check("valid_out", {63'h0, valid_out}, {63'h0, valid_in});
    check("ready_out", {63'h0, ready_out}, {63'h0, valid_in & ready_in & elast});
    if (valid_in) begin
      check("serial_out", {48'h0, serial_out}, {48'h0, eflit});
      check("last_out", {63'h0, last_out}, {63'h0, elast});
    end
    $display("t=%0t rst=%0b v=%0b rdy=%0b sel=%0b idx=%0d ser=%h last=%0b rout=%0b",
             $time, rst, valid_in, ready_in, count_sel, m_idx, serial_out, last_out, ready_out);
  endtask

  // Apply the inputs just after a rising edge, then sample and check at the falling edge.
  task automatic drive(input logic r, input logic v, input logic s,
                       input logic [31:0] p0, input logic [15:0] p1, input logic rd);
    rst = r; valid_in = v; count_sel = s;
    parallel_in_0 = p0; parallel_in_1 = p1; ready_in = rd;
    @(negedge clk);
    model_check();
  endtask

  // Move the model forward by one clock edge.
  task automatic tick();
    logic esel;
    int   n;
    @(posedge clk);
    esel = (m_idx == 0) ? count_sel : m_sel;
    n    = esel ? 1 : 2;
    if (!rst) begin
      m_idx = 0;
      m_sel = 1'b0;
    end else if (valid_in && ready_in) begin
      if (m_idx == 0) m_sel = count_sel;
      if (m_idx == n - 1) m_idx = 0;
      else m_idx = m_idx + 1;
    end
    #1;
  endtask

  initial begin
    rst = 1'b0; valid_in = 1'b0; count_sel = 1'b0;
    parallel_in_0 = '0; parallel_in_1 = '0; ready_in = 1'b0;

    // Hold reset for two cycles, then release it with no valid word.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
    check("idle_valid", {63'h0, valid_out}, 64'h0);
    check("idle_ready", {63'h0, ready_out}, 64'h0);
    tick();

    // Select 0 with no backpressure.
    drive(1'b1, 1'b1, 1'b0, 32'hBBBB_AAAA, 16'h0, 1'b1);
    check("s0_c1_ser", {48'h0, serial_out}, 64'hAAAA);
    check("s0_c1_last", {63'h0, last_out}, 64'h0);
    check("s0_c1_rdy", {63'h0, ready_out}, 64'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'hBBBB_AAAA, 16'h0, 1'b1);
    check("s0_c2_ser", {48'h0, serial_out}, 64'hBBBB);
    check("s0_c2_last", {63'h0, last_out}, 64'h1);
    check("s0_c2_rdy", {63'h0, ready_out}, 64'h1);
    tick();

    // Backpressure while the word sits at chunk 1.
    drive(1'b1, 1'b1, 1'b0, 32'hBBBB_AAAA, 16'h0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'hBBBB_AAAA, 16'h0, 1'b0);
      check("bp_ser", {48'h0, serial_out}, 64'hBBBB);
      check("bp_rdy", {63'h0, ready_out}, 64'h0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 32'hBBBB_AAAA, 16'h0, 1'b1);
    check("bp_release", {63'h0, ready_out}, 64'h1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'hBBBB_AAAA, 16'h0, 1'b1);
    check("bp_once", {63'h0, ready_out}, 64'h0);
    tick();

    // Select 1: four single-flit words sent back to back.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h0, 16'h1234 + 16'(i), 1'b1);
      check("s1_ser", {48'h0, serial_out}, {48'h0, 16'h1234 + 16'(i)});
      check("s1_last", {63'h0, last_out}, 64'h1);
      check("s1_rdy", {63'h0, ready_out}, 64'h1);
      tick();
    end

    // The select is latched on the first flit, so a later change of count_sel has no effect.
    drive(1'b1, 1'b1, 1'b0, 32'hBBBB_AAAA, 16'h5555, 1'b1); tick();
    drive(1'b1, 1'b1, 1'b1, 32'hBBBB_AAAA, 16'h5555, 1'b1);
    check("latch_ser", {48'h0, serial_out}, 64'hBBBB);
    check("latch_last", {63'h0, last_out}, 64'h1);
    tick();

    // Reset in the middle of a word.
    drive(1'b1, 1'b1, 1'b0, 32'hBBBB_AAAA, 16'h0, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 32'hBBBB_AAAA, 16'h0, 1'b1); tick();
    drive(1'b1, 1'b1, 1'b0, 32'hBBBB_AAAA, 16'h0, 1'b1);
    check("rst_mid_ser", {48'h0, serial_out}, 64'hAAAA);
    check("rst_mid_last", {63'h0, last_out}, 64'h0);
    tick();

    // Randomized traffic, with occasional resets and valid dropouts.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom), 32'($urandom), 16'($urandom), ($urandom_range(0, 2) != 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
